stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// ============================================================================
// Module  : stopwatch_core
// Brief   : BCD stopwatch (00.00 to 59.99) advanced by a synchronized slow
//           tick, with run/pause/clear control and an optional lap hold.
//           Optional feature macro: STOPWATCH_LAP_HOLD_EN (lap display hold).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_core #(
  parameter int SYNC_STAGES = 2  // tick_in synchronizer depth, legal 2..4
) (
  input  logic       clock,
  input  logic       rst,         // asynchronous, active-low
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic       running,
  output logic       wrap,
  output logic       lap_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_prev_q;
  logic                   ss_prev_q, clr_prev_q;
  logic [3:0]             cs1_q, cs10_q, s1_q, s10_q;
  logic [3:0]             cs1_d, cs10_d, s1_d, s10_d;
  logic                   wrap_q, wrap_d;

  logic tick_edge, ss_edge, clr_edge, inc;

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~tick_prev_q;
  assign ss_edge   = start_stop & ~ss_prev_q;
  assign clr_edge  = clear & ~clr_prev_q;
  // The increment is judged on the current state, so a tick coincident with
  // leaving RUN still counts and one coincident with entering RUN does not.
  assign inc       = (state_q == RUN) && tick_edge && !clr_edge;

  // Input synchronizer, tick edge register and button previous-value registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      tick_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
      tick_prev_q <= sync_q[SYNC_STAGES-1];
      ss_prev_q   <= start_stop;
      clr_prev_q  <= clear;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: clear has priority over start_stop
  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // BCD cascade next value and rollover pulse
  always_comb begin
    cs1_d  = cs1_q;
    cs10_d = cs10_q;
    s1_d   = s1_q;
    s10_d  = s10_q;
    wrap_d = 1'b0;
    if (clr_edge) begin
      cs1_d  = 4'd0;
      cs10_d = 4'd0;
      s1_d   = 4'd0;
      s10_d  = 4'd0;
    end else if (inc) begin
      wrap_d = (cs1_q == 4'd9) && (cs10_q == 4'd9) && (s1_q == 4'd9) && (s10_q == 4'd5);
      if (cs1_q != 4'd9) begin
        cs1_d = cs1_q + 4'd1;
      end else begin
        cs1_d = 4'd0;
        if (cs10_q != 4'd9) begin
          cs10_d = cs10_q + 4'd1;
        end else begin
          cs10_d = 4'd0;
          if (s1_q != 4'd9) begin
            s1_d = s1_q + 4'd1;
          end else begin
            s1_d  = 4'd0;
            s10_d = (s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1;
          end
        end
      end
    end
  end

  // Live count and wrap registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cs1_q  <= 4'd0;
      cs10_q <= 4'd0;
      s1_q   <= 4'd0;
      s10_q  <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      cs1_q  <= cs1_d;
      cs10_q <= cs10_d;
      s1_q   <= s1_d;
      s10_q  <= s10_d;
      wrap_q <= wrap_d;
    end
  end

  assign running = (state_q == RUN);
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        lap_prev_q;
  logic        lap_act_q, lap_act_d;
  logic [15:0] hold_q, hold_d;
  logic        lap_edge;

  assign lap_edge = lap & ~lap_prev_q;

  // Lap hold control: any exit from RUN releases; a lap edge in RUN toggles
  always_comb begin
    lap_act_d = lap_act_q;
    hold_d    = hold_q;
    if (state_d != RUN) begin
      lap_act_d = 1'b0;
    end else if (lap_edge && (state_q == RUN)) begin
      lap_act_d = ~lap_act_q;
      if (!lap_act_q) hold_d = {s10_q, s1_q, cs10_q, cs1_q};
    end
  end

  // Lap hold registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lap_prev_q <= 1'b0;
      lap_act_q  <= 1'b0;
      hold_q     <= 16'd0;
    end else begin
      lap_prev_q <= lap;
      lap_act_q  <= lap_act_d;
      hold_q     <= hold_d;
    end
  end

  assign lap_active = lap_act_q;
  assign {s_tens, s_ones, cs_tens, cs_ones} =
      lap_act_q ? hold_q : {s10_q, s1_q, cs10_q, cs1_q};
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign cs_ones    = cs1_q;
  assign cs_tens    = cs10_q;
  assign s_ones     = s1_q;
  assign s_tens     = s10_q;
`endif

endmodule

`default_nettype wire
